alarm_sweep_checker: RTL



---
 rtl/alarm_pkg.sv | 19 +
 rtl/sweep_settle_timer.sv | 28 ++
 rtl/alarm_sweep_checker.sv | 108 ++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for alarm-logic self-test sweeps.
package alarm_pkg;

  localparam int N_VEC = 8;
  localparam int VEC_W = 3;
  localparam int CNT_W = 4;
  localparam int ERR_W = 4;

  // Majority of A,B,C: minterms 3,5,6,7.
  localparam logic [N_VEC-1:0] ALARM_MAJORITY = 8'hE8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter with a zero flag; paces how long each sweep vector is held.
module sweep_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_sweep_checker.sv
// Sweeps all eight A,B,C vectors into an alarm block, compares its Y output
// against a truth table and reports a mismatch mask, error count and pass.
module alarm_sweep_checker
  import alarm_pkg::*;
#(
  parameter logic [N_VEC-1:0] EXPECTED      = ALARM_MAJORITY,
  parameter int               SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [VEC_W-1:0] abc_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_VEC-1:0] err_mask,
  output logic [ERR_W-1:0] err_count
);

  // The timer counts down to zero, so loading N-1 gives exactly N SETTLE cycles.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(N_VEC - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] idx;
  logic [CNT_W-1:0] settle_count;
  logic             settle_zero;
  logic             timer_load;
  logic             timer_dec;
  logic             last_vec;
  logic             mismatch;
  logic [ERR_W-1:0] err_count_nxt;

  assign last_vec      = (idx == LAST_IDX);
  // Case equality makes an X/Z on y_in count as a mismatch.
  assign mismatch      = !(y_in === EXPECTED[idx]);
  assign err_count_nxt = err_count + {{(ERR_W-1){1'b0}}, mismatch};

  assign timer_load = ((state == IDLE) && start) || ((state == SAMPLE) && !last_vec);
  assign timer_dec  = (state == SETTLE);

  sweep_settle_timer #(.W(CNT_W)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .count    (settle_count),
    .zero     (settle_zero)
  );

  // NOTE: next-state is assigned a default before the case so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETTLE;
      SETTLE:  if (settle_zero) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_vec ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      err_mask  <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            err_mask  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_mask[idx] <= 1'b1;
            err_count     <= err_count_nxt;
          end
          if (last_vec) begin
            idx  <= '0;
            pass <= (err_count_nxt == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == SETTLE) || (state == SAMPLE);
  assign done    = (state == DONE);
  assign abc_out = busy ? idx : '0;

  logic unused_count;
  assign unused_count = ^settle_count;

endmodule
